// File: rtl/apb_pkg.sv
// Shared definitions for the parametrised APB memory slave: FSM state
// encoding, response codes and the wait-state ceiling.
package apb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } apb_state_e;

  localparam logic APB_RESP_OKAY = 1'b0;
  localparam logic APB_RESP_ERR  = 1'b1;

  localparam int APB_MAX_WAIT_STATES = 15;
  localparam int APB_WAIT_CNT_W      = 4;

endpackage

// File: rtl/apb_slv_mem.sv
// DEPTH x DW storage array: synchronous write with per-byte enables,
// combinational read. Contents are deliberately not reset.
module apb_slv_mem
  import apb_pkg::*;
#(
  parameter int DW    = 8,
  parameter int AW    = 6,
  parameter int DEPTH = 64
) (
  input  logic            i_clk,
  input  logic            i_we,
  input  logic [DW/8-1:0] i_be,
  input  logic [AW-1:0]   i_waddr,
  input  logic [DW-1:0]   i_wdata,
  input  logic [AW-1:0]   i_raddr,
  output logic [DW-1:0]   o_rdata
);

  logic [DW-1:0] r_mem [DEPTH];

  // Byte-lane write; a lane with its enable low keeps its old contents.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      for (int b = 0; b < DW/8; b++) begin
        if (i_be[b]) begin
          r_mem[i_waddr][b*8 +: 8] <= i_wdata[b*8 +: 8];
        end
      end
    end
  end

  // The caller only consumes this when the address is in range.
  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/apb_mem_slave.sv
// Parametrised APB memory slave with programmable wait states, registered
// PREADY/PRDATA/PSLVERR and out-of-range error response.
// Optional feature macro: APB_SLV_PSTRB_EN adds the PSTRB byte-lane port.
module apb_mem_slave
  import apb_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 7,
  parameter int DEPTH       = 64,
  parameter int WAIT_STATES = 0
) (
  input  logic                    PCLK,
  input  logic                    PRESET,
  input  logic                    PSELECT,
  input  logic                    PENABLE,
  input  logic                    PWRITE,
  input  logic [ADDR_WIDTH-1:0]   PADDR,
  input  logic [DATA_WIDTH-1:0]   PWDATA,
`ifdef APB_SLV_PSTRB_EN
  input  logic [DATA_WIDTH/8-1:0] PSTRB,
`endif
  output logic [DATA_WIDTH-1:0]   PRDATA,
  output logic                    PREADY,
  output logic                    PSLVERR
);

  localparam int NB     = DATA_WIDTH / 8;
  localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0]       DEPTH_L = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [APB_WAIT_CNT_W-1:0] WAIT_L  = APB_WAIT_CNT_W'(WAIT_STATES);
  localparam logic [APB_WAIT_CNT_W-1:0] CNT_ONE = APB_WAIT_CNT_W'(1);

  apb_state_e                r_state;
  logic [APB_WAIT_CNT_W-1:0] r_cnt;
  logic [ADDR_WIDTH-1:0]     r_addr;
  logic                      r_write;
  logic [DATA_WIDTH-1:0]     r_wdata;
  logic [NB-1:0]             r_strb;
  logic                      r_ready;
  logic                      r_slverr;
  logic [DATA_WIDTH-1:0]     r_rdata;

  logic [NB-1:0]             w_strb;
  logic [ADDR_WIDTH-1:0]     w_raddr;
  logic                      w_in_range;
  logic                      w_access_ok;
  logic                      w_commit;
  logic                      w_mem_we;
  logic [DATA_WIDTH-1:0]     w_mem_rdata;
  logic [DATA_WIDTH-1:0]     w_load_rdata;

`ifdef APB_SLV_PSTRB_EN
  assign w_strb = PSTRB;
`else
  assign w_strb = '1;
`endif

  // With zero wait states the response is formed on the setup edge, before
  // the address has been captured, so the lookup follows the live bus there.
  assign w_raddr      = (r_state == IDLE) ? PADDR : r_addr;
  assign w_in_range   = ({1'b0, w_raddr} < DEPTH_L);
  assign w_access_ok  = PSELECT && PENABLE;
  assign w_commit     = !PRESET && (r_state == ACCESS) && r_ready && w_access_ok;
  assign w_mem_we     = w_commit && r_write && w_in_range;
  assign w_load_rdata = w_in_range ? w_mem_rdata : '0;

  apb_slv_mem #(
    .DW    (DATA_WIDTH),
    .AW    (MEM_AW),
    .DEPTH (DEPTH)
  ) u_mem (
    .i_clk   (PCLK),
    .i_we    (w_mem_we),
    .i_be    (r_strb),
    .i_waddr (r_addr[MEM_AW-1:0]),
    .i_wdata (r_wdata),
    .i_raddr (w_raddr[MEM_AW-1:0]),
    .o_rdata (w_mem_rdata)
  );

  // Transfer FSM: setup capture, wait countdown, response and commit/abort.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_addr   <= '0;
      r_write  <= 1'b0;
      r_wdata  <= '0;
      r_strb   <= '0;
      r_ready  <= 1'b0;
      r_slverr <= 1'b0;
      r_rdata  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (PSELECT && !PENABLE) begin
            r_addr  <= PADDR;
            r_write <= PWRITE;
            r_wdata <= PWDATA;
            r_strb  <= w_strb;
            r_cnt   <= WAIT_L;
            r_state <= ACCESS;
            if (WAIT_L == '0) begin
              r_ready  <= 1'b1;
              r_slverr <= w_in_range ? APB_RESP_OKAY : APB_RESP_ERR;
              if (!PWRITE) begin
                r_rdata <= w_load_rdata;
              end
            end
          end
        end
        ACCESS: begin
          if (!w_access_ok) begin
            // Master walked away: drop the transfer without writing.
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_ready  <= 1'b0;
            r_slverr <= 1'b0;
          end else if (r_ready) begin
            r_state  <= IDLE;
            r_ready  <= 1'b0;
            r_slverr <= 1'b0;
          end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_ONE;
            if (r_cnt == CNT_ONE) begin
              r_ready  <= 1'b1;
              r_slverr <= w_in_range ? APB_RESP_OKAY : APB_RESP_ERR;
              if (!r_write) begin
                r_rdata <= w_load_rdata;
              end
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign PRDATA  = r_rdata;
  assign PREADY  = r_ready;
  assign PSLVERR = r_slverr;

endmodule

// File: tb/tb_apb_mem_slave.sv
// Bench for apb_mem_slave: two slaves share one APB bus. Slave 0 has no wait
// states and DEPTH=48 (out-of-range window above 47); slave 1 has 3 wait
// states and spans the full 7-bit address space. A driver issues directed
// and random transfers and pushes expected responses; a monitor pops and
// compares whenever a slave raises PREADY.
module tb_apb_mem_slave;

`ifdef APB_SLV_PSTRB_EN
  localparam int DW = 32;
`else
  localparam int DW = 8;
`endif
  localparam int NB = DW / 8;

  typedef struct {
    int            cyc;
    logic          err;
    logic [DW-1:0] rdata;
  } exp_t;

  logic          PCLK = 1'b0;
  logic          PRESET;
  logic          PENABLE;
  logic          PWRITE;
  logic [1:0]    psel;
  logic [6:0]    PADDR;
  logic [DW-1:0] PWDATA;
  logic [NB-1:0] PSTRB;
  logic [DW-1:0] prdata0, prdata1;
  logic          pready0, pready1, pslverr0, pslverr1;

  exp_t q0[$];
  exp_t q1[$];
  logic [DW-1:0] m0 [128];
  logic [DW-1:0] m1 [128];
  logic [DW-1:0] last0, last1;
  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  apb_mem_slave #(.DATA_WIDTH(DW), .ADDR_WIDTH(7), .DEPTH(48), .WAIT_STATES(0)) u_s0 (
    .PCLK(PCLK), .PRESET(PRESET), .PSELECT(psel[0]), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
`ifdef APB_SLV_PSTRB_EN
    .PSTRB(PSTRB),
`endif
    .PRDATA(prdata0), .PREADY(pready0), .PSLVERR(pslverr0));

  apb_mem_slave #(.DATA_WIDTH(DW), .ADDR_WIDTH(7), .DEPTH(128), .WAIT_STATES(3)) u_s1 (
    .PCLK(PCLK), .PRESET(PRESET), .PSELECT(psel[1]), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
`ifdef APB_SLV_PSTRB_EN
    .PSTRB(PSTRB),
`endif
    .PRDATA(prdata1), .PREADY(pready1), .PSLVERR(pslverr1));

  always #5 PCLK = ~PCLK;
  always @(posedge PCLK) cyc <= cyc + 1;

  function automatic int ws(input int s);
    return (s == 0) ? 0 : 3;
  endfunction

  function automatic bit inr(input int s, input int a);
    return a < ((s == 0) ? 48 : 128);
  endfunction

  function automatic logic [DW-1:0] mrd(input int s, input int a);
    if (!inr(s, a)) return '0;
    return (s == 0) ? m0[a] : m1[a];
  endfunction

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_v,
                                          input logic [DW-1:0] new_v,
                                          input logic [NB-1:0] st);
    logic [DW-1:0] r;
    r = old_v;
    for (int b = 0; b < NB; b++)
      if (st[b]) r[b*8 +: 8] = new_v[b*8 +: 8];
    return r;
  endfunction

  task automatic chk(input string name, input int s, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s slave%0d got=%0h exp=%0h", name, s, got, exp);
    end
  endtask

  task automatic check_reset_outputs();
    @(negedge PCLK);
    chk("rst_pready", 0, 64'(pready0), 0);
    chk("rst_pslverr", 0, 64'(pslverr0), 0);
    chk("rst_prdata", 0, 64'(prdata0), 0);
    chk("rst_pready", 1, 64'(pready1), 0);
    chk("rst_pslverr", 1, 64'(pslverr1), 0);
    chk("rst_prdata", 1, 64'(prdata1), 0);
  endtask

  task automatic idle();
    psel = 2'b00; PENABLE = 1'b0;
    @(posedge PCLK); #1;
  endtask

  task automatic do_reset(input int n);
    psel = 2'b00; PENABLE = 1'b0; PRESET = 1'b1;
    repeat (n) @(posedge PCLK);
    #1 PRESET = 1'b0;
    last0 = '0; last1 = '0;
    check_reset_outputs();
    @(posedge PCLK); #1;
  endtask

  // ab_k = 0: normal transfer. ab_k > 0: the transfer is cut in access
  // cycle ab_k, either by dropping PSELECT or (rst_ab) by asserting PRESET.
  task automatic xfer(input int s, input bit wr, input int a, input logic [DW-1:0] d,
                      input logic [NB-1:0] st, input int ab_k, input bit rst_ab);
    exp_t e;
    bit rdy;
    int n;
    logic [NB-1:0] eff;
`ifdef APB_SLV_PSTRB_EN
    eff = st;
`else
    eff = '1;
`endif
    psel = (s == 0) ? 2'b01 : 2'b10;
    PENABLE = 1'b0; PWRITE = wr; PADDR = a[6:0]; PWDATA = d; PSTRB = st;
    if (ab_k == 0 || (!rst_ab && ab_k == ws(s) + 1)) begin
      e.cyc = cyc + 1 + ws(s);
      e.err = !inr(s, a);
      if (wr) e.rdata = (s == 0) ? last0 : last1;
      else begin
        e.rdata = mrd(s, a);
        if (s == 0) last0 = e.rdata; else last1 = e.rdata;
      end
      if (s == 0) q0.push_back(e); else q1.push_back(e);
    end
    if (ab_k == 0) begin
      @(posedge PCLK); #1 PENABLE = 1'b1;
      rdy = 1'b0; n = 0;
      while (!rdy) begin
        @(negedge PCLK);
        rdy = (s == 0) ? pready0 : pready1;
        @(posedge PCLK); #1;
        n++;
        if (!rdy && n > 40) begin
          total++; bad++;
          $display("FAIL pready_timeout slave%0d got=0 exp=1", s);
          break;
        end
      end
      if (wr && inr(s, a)) begin
        if (s == 0) m0[a] = merge(m0[a], d, eff);
        else        m1[a] = merge(m1[a], d, eff);
      end
    end else begin
      for (int j = 1; j <= ab_k; j++) begin
        @(posedge PCLK); #1;
        if (j < ab_k) PENABLE = 1'b1;
        else if (rst_ab) begin PENABLE = 1'b1; PRESET = 1'b1; end
        else begin psel = 2'b00; PENABLE = 1'b0; end
      end
      @(posedge PCLK); #1;
      if (rst_ab) begin
        PRESET = 1'b0; psel = 2'b00; PENABLE = 1'b0;
        last0 = '0; last1 = '0;
        check_reset_outputs();
        @(posedge PCLK); #1;
      end
    end
  endtask

  // Monitor: every PREADY pulse must match the oldest expected response.
  initial begin
    exp_t e;
    forever begin
      @(negedge PCLK);
      if (pready0) begin
        if (q0.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_pready slave0 got=1 exp=0");
        end else begin
          e = q0.pop_front();
          chk("ready_cyc", 0, 64'(cyc), 64'(e.cyc));
          chk("pslverr", 0, 64'(pslverr0), 64'(e.err));
          chk("prdata", 0, 64'(prdata0), 64'(e.rdata));
        end
      end
      if (pready1) begin
        if (q1.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_pready slave1 got=1 exp=0");
        end else begin
          e = q1.pop_front();
          chk("ready_cyc", 1, 64'(cyc), 64'(e.cyc));
          chk("pslverr", 1, 64'(pslverr1), 64'(e.err));
          chk("prdata", 1, 64'(prdata1), 64'(e.rdata));
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int s, a, k;
    bit wr;
    PRESET = 1'b1; psel = 2'b00; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = '0; PWDATA = '0; PSTRB = '0;
    last0 = '0; last1 = '0;
    @(posedge PCLK); #1;
    do_reset(2);

    for (int i = 0; i < 48; i++)  xfer(0, 1'b1, i, DW'($urandom), '1, 0, 1'b0);
    for (int i = 0; i < 128; i++) xfer(1, 1'b1, i, DW'($urandom), '1, 0, 1'b0);

    xfer(0, 1'b1, 3, DW'(8'hA5), '1, 0, 1'b0);
    xfer(0, 1'b0, 3, '0, '1, 0, 1'b0);
    xfer(1, 1'b1, 10, DW'(8'h3C), '1, 0, 1'b0);
    xfer(1, 1'b0, 10, '0, '1, 0, 1'b0);
    xfer(0, 1'b1, 48, DW'(8'hFF), '1, 0, 1'b0);
    xfer(0, 1'b0, 47, '0, '1, 0, 1'b0);
    xfer(0, 1'b0, 48, '0, '1, 0, 1'b0);
    xfer(0, 1'b0, 127, '0, '1, 0, 1'b0);
    idle();

    xfer(1, 1'b1, 5, DW'(8'h77), '1, 0, 1'b0);
    xfer(1, 1'b1, 5, DW'(8'h11), '1, 2, 1'b0);
    xfer(1, 1'b0, 5, '0, '1, 0, 1'b0);
    xfer(1, 1'b1, 5, DW'(8'h11), '1, 2, 1'b1);
    xfer(1, 1'b0, 5, '0, '1, 0, 1'b0);
    xfer(0, 1'b1, 7, DW'(8'h5A), '1, 1, 1'b0);
    xfer(0, 1'b0, 7, '0, '1, 0, 1'b0);

`ifdef APB_SLV_PSTRB_EN
    xfer(0, 1'b1, 0, 32'hDEADBEEF, 4'hF, 0, 1'b0);
    xfer(0, 1'b1, 0, 32'h00000000, 4'h5, 0, 1'b0);
    xfer(0, 1'b0, 0, '0, 4'h0, 0, 1'b0);
    xfer(0, 1'b1, 0, 32'h12345678, 4'h0, 0, 1'b0);
    xfer(0, 1'b0, 0, '0, 4'h0, 0, 1'b0);
    chk("pstrb_merge", 0, 64'(m0[0]), 64'h00000000DE00BE00);
`endif

    for (int i = 0; i < 300; i++) begin
      s  = int'($urandom_range(0, 1));
      wr = 1'($urandom);
      a  = (s == 0) ? int'($urandom_range(0, 63)) : int'($urandom_range(0, 127));
      k  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, ws(s) + 1)) : 0;
      xfer(s, wr, a, DW'($urandom), NB'($urandom), k, 1'b0);
      if ($urandom_range(0, 3) == 0) idle();
    end

    repeat (4) idle();
    chk("queue_empty", 0, 64'(q0.size()), 0);
    chk("queue_empty", 1, 64'(q1.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
